// File: rtl/mrc_pkg.sv
// Shared state encoding and packed-region helper for the memory result checker.
// No logic of its own; imported by the checker and its region decoder.
package mrc_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_HALT,
      ST_SCAN,
      ST_DRAIN,
      ST_DONE
   } state_t;

   // Bit offset of region r inside a packed per-region bound vector.
   function automatic int region_lsb(input int r, input int addr_w);
      return r * addr_w;
   endfunction

endpackage

// File: rtl/mrc_region_hit.sv
// Combinational region decoder: flags every region whose inclusive [lo, hi] range contains k.
// Zero latency; no backpressure. A region with lo > hi can never match and is therefore disabled.
module mrc_region_hit
   import mrc_pkg::*;
#(
   parameter int ADDR_W      = 10,
   parameter int NUM_REGIONS = 8
) (
   input  logic [ADDR_W-1:0]             k,
   input  logic [NUM_REGIONS*ADDR_W-1:0] region_lo,
   input  logic [NUM_REGIONS*ADDR_W-1:0] region_hi,
   output logic [NUM_REGIONS-1:0]        hit
);

   always_comb begin
      hit = '0;
      for (int r = 0; r < NUM_REGIONS; r++) begin
         if ((k >= region_lo[region_lsb(r, ADDR_W) +: ADDR_W]) &&
             (k <= region_hi[region_lsb(r, ADDR_W) +: ADDR_W]))
            hit[r] = 1'b1;
      end
   end

endmodule

// File: rtl/mem_result_checker.sv
// Waits for program halt, then scans DUT memory against golden memory and flags mismatches per region.
// One read per cycle with one-cycle read latency; no backpressure, both memories must answer every strobe.
module mem_result_checker
   import mrc_pkg::*;
#(
   parameter int ADDR_W      = 10,
   parameter int WORD_W      = 32,
   parameter int HALT_COUNT  = 10,
   parameter int ZERO_RUN    = 10,
   parameter int NUM_REGIONS = 8,
   parameter int TIMEOUT     = 65535
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic [31:0]                   inst,
   output logic                          dut_rd_en,
   output logic [ADDR_W-1:0]             dut_addr,
   input  logic [WORD_W-1:0]             dut_rd_data,
   output logic                          gold_rd_en,
   output logic [ADDR_W-1:0]             gold_addr,
   input  logic [WORD_W-1:0]             gold_rd_data,
   input  logic [NUM_REGIONS*ADDR_W-1:0] region_lo,
   input  logic [NUM_REGIONS*ADDR_W-1:0] region_hi,
   output logic                          busy,
   output logic                          done,
   output logic                          pass,
   output logic                          timeout,
   output logic [NUM_REGIONS-1:0]        region_err,
   output logic [ADDR_W-1:0]             first_err_idx,
   output logic [ADDR_W:0]               words_checked
);

   localparam int HW = $clog2(HALT_COUNT + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int ZW = $clog2(ZERO_RUN + 1);
   localparam logic [HW-1:0] HALT_LAST  = HW'(HALT_COUNT - 1);
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
   localparam logic [ZW-1:0] ZERO_LAST  = ZW'(ZERO_RUN - 1);

   state_t                 state;
   logic                   rd_en;
   logic [ADDR_W-1:0]      scan_idx;
   logic [ADDR_W-1:0]      cmp_idx;
   logic                   cmp_vld;
   logic [HW-1:0]          halt_cnt;
   logic [TW-1:0]          timer;
   logic [ZW-1:0]          zero_cnt;
   logic [NUM_REGIONS-1:0] hit;
   logic [NUM_REGIONS-1:0] err_set;
   logic                   dut_zero;
   logic                   zero_end;
   logic                   halt_now;
   logic                   timer_end;
   logic                   scan_last;

   mrc_region_hit #(
      .ADDR_W      (ADDR_W),
      .NUM_REGIONS (NUM_REGIONS)
   ) u_region_hit (
      .k         (cmp_idx),
      .region_lo (region_lo),
      .region_hi (region_hi),
      .hit       (hit)
   );

   // Compare stage sees the word read in the previous cycle, tagged with cmp_idx.
   assign err_set   = (cmp_vld && (dut_rd_data != gold_rd_data)) ? hit : '0;
   assign dut_zero  = (dut_rd_data == '0);
   assign zero_end  = cmp_vld && dut_zero && (zero_cnt == ZERO_LAST);
   assign halt_now  = (inst == 32'h0) && (halt_cnt == HALT_LAST);
   assign timer_end = (timer == TIMER_LAST);
   assign scan_last = (scan_idx == '1);

   assign dut_rd_en  = rd_en;
   assign gold_rd_en = rd_en;
   assign dut_addr   = scan_idx;
   assign gold_addr  = scan_idx;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= ST_IDLE;
         rd_en         <= 1'b0;
         scan_idx      <= '0;
         cmp_idx       <= '0;
         cmp_vld       <= 1'b0;
         halt_cnt      <= '0;
         timer         <= '0;
         zero_cnt      <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         pass          <= 1'b0;
         timeout       <= 1'b0;
         region_err    <= '0;
         first_err_idx <= '0;
         words_checked <= '0;
      end else begin
         cmp_vld <= 1'b0;
         if (cmp_vld) begin
            words_checked <= words_checked + 1'b1;
            zero_cnt      <= dut_zero ? zero_cnt + 1'b1 : '0;
            region_err    <= region_err | err_set;
            if ((|err_set) && !(|region_err))
               first_err_idx <= cmp_idx;
         end

         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state         <= ST_WAIT_HALT;
                  busy          <= 1'b1;
                  done          <= 1'b0;
                  pass          <= 1'b0;
                  timeout       <= 1'b0;
                  region_err    <= '0;
                  first_err_idx <= '0;
                  words_checked <= '0;
                  halt_cnt      <= '0;
                  timer         <= '0;
                  zero_cnt      <= '0;
                  scan_idx      <= '0;
               end
            end

            ST_WAIT_HALT: begin
               timer <= timer + 1'b1;
               if (inst == 32'h0)
                  halt_cnt <= halt_cnt + 1'b1;
               // Halt takes priority over a timeout expiring in the same cycle.
               if (halt_now) begin
                  state    <= ST_SCAN;
                  rd_en    <= 1'b1;
                  scan_idx <= '0;
               end else if (timer_end) begin
                  state   <= ST_DONE;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  pass    <= 1'b0;
                  timeout <= 1'b1;
               end
            end

            ST_SCAN: begin
               cmp_vld <= 1'b1;
               cmp_idx <= scan_idx;
               if (!scan_last)
                  scan_idx <= scan_idx + 1'b1;
               // A completed zero run drops the read issued this cycle uncompared.
               if (zero_end) begin
                  cmp_vld <= 1'b0;
                  state   <= ST_DRAIN;
                  rd_en   <= 1'b0;
               end else if (scan_last) begin
                  state <= ST_DRAIN;
                  rd_en <= 1'b0;
               end
            end

            ST_DRAIN: begin
               if (!cmp_vld) begin
                  state <= ST_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= !(|region_err);
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
